// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the two-port RAM access arbiter.
// Optional feature macro: RAM_ARB_ROUND_ROBIN_EN (round-robin instead of fixed priority).
package ram_arb_pkg;

    localparam int DEFAULT_ADDR_W = 16;
    localparam int DEFAULT_DATA_W = 32;
    localparam int NUM_PORTS      = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_t;

endpackage

// File: rtl/ram_arb_pick.sv
// Combinational winner select between the fetch port (0) and load/store port (1).
// With RAM_ARB_ROUND_ROBIN_EN defined, a tie goes to the port not granted last;
// otherwise port 0 always wins a tie.
module ram_arb_pick
    import ram_arb_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
`ifdef RAM_ARB_ROUND_ROBIN_EN
    input  logic                 last_port,
`endif
    output logic                 grant_valid,
    output logic                 grant_port
);

    // Pick the winning port from the current requests
    always_comb begin
        grant_valid = |req;
        grant_port  = 1'b0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
        if (req[0] && req[1]) begin
            grant_port = ~last_port;
        end else begin
            grant_port = req[1];
        end
`else
        grant_port = req[1] && !req[0];
`endif
    end

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester access controller for a single-port asynchronous RAM.
// Each access runs IDLE (sample/grant) -> ACCESS (RAM phase) -> DONE (ack pulse).
// Optional feature macro: RAM_ARB_ROUND_ROBIN_EN selects round-robin arbitration;
// without it port 0 has fixed priority and no pointer register is built.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_PORTS-1:0] req,
    input  logic [NUM_PORTS-1:0] we,
    input  logic [ADDR_W-1:0]    addr0,
    input  logic [ADDR_W-1:0]    addr1,
    input  logic [DATA_W-1:0]    wdata0,
    input  logic [DATA_W-1:0]    wdata1,
    output logic [NUM_PORTS-1:0] ack,
    output logic [DATA_W-1:0]    rdata,
    output logic                 ram_rw,
    output logic [ADDR_W-1:0]    ram_addr,
    output logic [DATA_W-1:0]    ram_wdata,
    input  logic [DATA_W-1:0]    ram_rdata
);

    arb_state_t state;
    arb_state_t state_next;
    logic       cur_we;
    logic       cur_port;
    logic       grant_valid;
    logic       grant_port;

`ifdef RAM_ARB_ROUND_ROBIN_EN
    logic       last_port;
`endif

    ram_arb_pick u_pick (
        .req         (req),
`ifdef RAM_ARB_ROUND_ROBIN_EN
        .last_port   (last_port),
`endif
        .grant_valid (grant_valid),
        .grant_port  (grant_port)
    );

    // State register; reset drops straight back to IDLE, aborting any access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: requests are only looked at in IDLE
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_valid) state_next = ACCESS;
            ACCESS:  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath registers: latch the winner's payload in IDLE, drive the RAM
    // write strobe only during ACCESS, capture read data and pulse ack into DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_rw    <= 1'b0;
            ack       <= '0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            rdata     <= '0;
            cur_we    <= 1'b0;
            cur_port  <= 1'b0;
        end else begin
            ram_rw <= 1'b0;
            ack    <= '0;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        ram_addr  <= grant_port ? addr1  : addr0;
                        ram_wdata <= grant_port ? wdata1 : wdata0;
                        cur_we    <= we[grant_port];
                        cur_port  <= grant_port;
                        ram_rw    <= we[grant_port];
                    end
                end
                ACCESS: begin
                    if (!cur_we) begin
                        rdata <= ram_rdata;
                    end
                    ack[cur_port] <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef RAM_ARB_ROUND_ROBIN_EN
    // Remember the last granted port; reset value makes port 0 win the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_port <= 1'b1;
        end else if (state == IDLE && grant_valid) begin
            last_port <= grant_port;
        end
    end
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: stimulus pushes expected acks into a queue,
// a monitor pops and compares on every ack pulse.
module tb_ram_arbiter;

    typedef struct {
        int          port;
        bit          is_read;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [15:0] addr0;
    logic [15:0] addr1;
    logic [31:0] wdata0;
    logic [31:0] wdata1;
    logic [1:0]  ack;
    logic [31:0] rdata;
    logic        ram_rw;
    logic [15:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    logic [31:0] mem [0:65535];
    exp_t        exp_q[$];
    exp_t        mon_item;
    int          checks = 0;
    int          failures = 0;
    int          rw_count = 0;

    ram_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .we        (we),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .ack       (ack),
        .rdata     (rdata),
        .ram_rw    (ram_rw),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    always #5 clk = ~clk;

    // Asynchronous RAM model: combinational read, write while ram_rw is high
    assign ram_rdata = mem[ram_addr];

    always @(posedge clk) begin
        if (!rst_n) begin
            mem[16'h0001] <= 32'h0000_000A;
            mem[16'h0002] <= 32'h0000_000B;
            mem[16'h0005] <= 32'h0000_0055;
            mem[16'h0006] <= 32'h0000_0066;
        end else if (ram_rw) begin
            mem[ram_addr] <= ram_wdata;
        end
    end

    // Count cycles with the write strobe high
    always @(posedge clk) begin
        if (ram_rw) rw_count++;
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    // Monitor: every ack pulse must be one-hot and match the scoreboard head
    always @(negedge clk) begin
        if (rst_n && ack != 2'b00) begin
            check_output("ack_onehot", 32'(ack == 2'b01 || ack == 2'b10), 32'd1);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_ack: got ack=%b expected none", ack);
            end else begin
                mon_item = exp_q.pop_front();
                check_output("ack_port", 32'(ack), (mon_item.port == 1) ? 32'd2 : 32'd1);
                if (mon_item.is_read) check_output("rdata", rdata, mon_item.data);
            end
        end
    end

    task automatic apply_stimulus(input int port, input bit is_write,
                                  input logic [15:0] a, input logic [31:0] d);
        if (port == 0) begin
            req[0] = 1'b1; we[0] = is_write; addr0 = a; wdata0 = d;
        end else begin
            req[1] = 1'b1; we[1] = is_write; addr1 = a; wdata1 = d;
        end
    endtask

    task automatic expect_ack(input int port, input bit is_read, input logic [31:0] d);
        exp_t e;
        e.port = port;
        e.is_read = is_read;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic drop_req(input int port);
        req[port] = 1'b0;
        we[port]  = 1'b0;
    endtask

    task automatic wait_ack(input int port, input string name, output int cycles);
        cycles = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (ack[port]) begin
                cycles = i;
                return;
            end
        end
        checks++;
        failures++;
        $display("[TB] FAIL %s_timeout: got no ack[%0d] expected one within 20 cycles", name, port);
    endtask

    initial begin
        int cyc;
        int rw_before;
        int exp_port;

        rst_n = 1'b0;
        req = 2'b00; we = 2'b00;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        repeat (2) @(negedge clk);

        $display("[TB] reset values");
        check_output("rst_ram_rw", 32'(ram_rw), 32'd0);
        check_output("rst_ack", 32'(ack), 32'd0);
        check_output("rst_ram_addr", 32'(ram_addr), 32'd0);
        check_output("rst_ram_wdata", ram_wdata, 32'd0);
        check_output("rst_rdata", rdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] port 1 write then read");
        rw_before = rw_count;
        apply_stimulus(1, 1'b1, 16'h1234, 32'hDEAD_BEEF);
        expect_ack(1, 1'b0, 32'h0);
        wait_ack(1, "wr", cyc);
        check_output("wr_latency", 32'(cyc), 32'd2);
        check_output("wr_done_ram_rw", 32'(ram_rw), 32'd0);
        check_output("wr_done_ram_addr", 32'(ram_addr), 32'h1234);
        drop_req(1);
        @(negedge clk);
        check_output("wr_rw_cycles", 32'(rw_count - rw_before), 32'd1);
        check_output("wr_mem", mem[16'h1234], 32'hDEAD_BEEF);

        rw_before = rw_count;
        apply_stimulus(1, 1'b0, 16'h1234, 32'h0);
        expect_ack(1, 1'b1, 32'hDEAD_BEEF);
        wait_ack(1, "rd", cyc);
        check_output("rd_latency", 32'(cyc), 32'd2);
        drop_req(1);
        @(negedge clk);
        check_output("rd_rw_cycles", 32'(rw_count - rw_before), 32'd0);

        $display("[TB] both ports reading continuously");
        apply_stimulus(0, 1'b0, 16'h0001, 32'h0);
        apply_stimulus(1, 1'b0, 16'h0002, 32'h0);
        for (int k = 0; k < 4; k++) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
            exp_port = k % 2;
`else
            exp_port = 0;
`endif
            expect_ack(exp_port, 1'b1, (exp_port == 0) ? 32'h0000_000A : 32'h0000_000B);
        end
        for (int k = 0; k < 4; k++) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
            exp_port = k % 2;
`else
            exp_port = 0;
`endif
            wait_ack(exp_port, "both", cyc);
            check_output("both_spacing", 32'(cyc), (k == 0) ? 32'd2 : 32'd3);
        end
        drop_req(0);
        drop_req(1);
        @(negedge clk);

        $display("[TB] late request from port 1");
        apply_stimulus(0, 1'b0, 16'h0001, 32'h0);
        expect_ack(0, 1'b1, 32'h0000_000A);
        expect_ack(1, 1'b1, 32'h0000_000B);
        @(negedge clk);
        apply_stimulus(1, 1'b0, 16'h0002, 32'h0);
        wait_ack(0, "late0", cyc);
        check_output("late0_latency", 32'(cyc), 32'd1);
        drop_req(0);
        wait_ack(1, "late1", cyc);
        check_output("late1_gap", 32'(cyc), 32'd3);
        drop_req(1);
        @(negedge clk);

        $display("[TB] payload change after sampling");
        apply_stimulus(0, 1'b0, 16'h0005, 32'h0);
        expect_ack(0, 1'b1, 32'h0000_0055);
        @(negedge clk);
        addr0 = 16'h0006;
        check_output("chg_access_addr", 32'(ram_addr), 32'h0005);
        wait_ack(0, "chg", cyc);
        check_output("chg_latency", 32'(cyc), 32'd1);
        check_output("chg_done_addr", 32'(ram_addr), 32'h0005);
        drop_req(0);
        @(negedge clk);

        $display("[TB] reset during write access");
        apply_stimulus(0, 1'b1, 16'h0010, 32'h1111_1111);
        @(negedge clk);
        check_output("abort_ram_rw_before", 32'(ram_rw), 32'd1);
        check_output("abort_ram_addr_before", 32'(ram_addr), 32'h0010);
        rst_n = 1'b0;
        #1;
        check_output("abort_ram_rw", 32'(ram_rw), 32'd0);
        check_output("abort_ack", 32'(ack), 32'd0);
        check_output("abort_ram_addr", 32'(ram_addr), 32'd0);
        check_output("abort_ram_wdata", ram_wdata, 32'd0);
        check_output("abort_rdata", rdata, 32'd0);
        drop_req(0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] tie right after reset");
        apply_stimulus(0, 1'b0, 16'h0001, 32'h0);
        apply_stimulus(1, 1'b0, 16'h0002, 32'h0);
        expect_ack(0, 1'b1, 32'h0000_000A);
        expect_ack(1, 1'b1, 32'h0000_000B);
        wait_ack(0, "tie0", cyc);
        check_output("tie0_latency", 32'(cyc), 32'd2);
        drop_req(0);
        wait_ack(1, "tie1", cyc);
        check_output("tie1_gap", 32'(cyc), 32'd3);
        drop_req(1);
        repeat (3) @(negedge clk);

        check_output("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
